csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
Drives the write side of the machine-mode CSR file (mepc/mcause/mstatus/mtvec) and consumes its read-back values. It sequences ecall trap entry, mret return, and Zicsr read-modify-write instructions. It also produces the PC redirect for IFU. It sits between EXU and the CSR file and accepts one instruction at a time via a valid/ready handshake.

Parameters:
XLEN, 32, data/PC width
ECALL_CAUSE, 32'd11, mcause value written on ecall (environment call from M-mode)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
inst_valid  in  1  EXU presents a system instruction
inst_ready  out  1  block can accept (high only in IDLE)
is_ecall  in  1  instruction is ecall
is_mret  in  1  instruction is mret
csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
csr_addr  in  12  CSR address
csr_src  in  XLEN  rs1 value
pc  in  XLEN  PC of the instruction
mepc_out/mcause_out/mstatus_out/mtvec_out  in  XLEN each  current CSR values
mepc_in/mcause_in/mstatus_in/mtvec_in  out  XLEN each  CSR write data
csr_wen  out  4  write enables: [0] mepc, [1] mcause, [2] mstatus, [3] mtvec
csr_rdata  out  XLEN  old CSR value for rd; valid when done=1
done  out  1  one-cycle completion pulse
redirect_valid  out  1  one-cycle PC redirect pulse
redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0, including csr_wen, redirect_valid, done, csr_rdata and the *_in buses. inst_ready=0 while rst is high and 1 once released.
- Accept: inst_valid & inst_ready in IDLE. The block latches pc, csr_op, csr_addr, csr_src and the instruction kind. Priority: ecall > mret > csr_op!=0. If none is set, the block returns done on the next cycle with no writes.
- States: IDLE, TRAP_SAVE, TRAP_JUMP, MRET, CSR_EXEC.
- ecall (accept at cycle N):
  - N+1 TRAP_SAVE: csr_wen=0111, mepc_in=pc, mcause_in=ECALL_CAUSE. mstatus_in = mstatus_out with MPIE(bit7)=MIE(bit3), MIE=0, MPP(12:11)=11.
  - N+2 TRAP_JUMP: redirect_valid=1, redirect_pc={mtvec_out[XLEN-1:2],2'b00}, done=1. Then IDLE.
- mret (accept N): N+1 MRET does all of the following, then IDLE:
  - csr_wen=0100; mstatus_in with MIE=MPIE, MPIE=1, MPP=11.
  - redirect_valid=1, redirect_pc=mepc_out, done=1.
- CSR instruction (accept N): N+1 CSR_EXEC does the following, then IDLE:
  - csr_rdata = current value of the addressed CSR.
  - new value: RW=src, RS=old|src, RC=old&~src.
  - Enable bit set for the addressed CSR only. RS/RC with csr_src==0 write nothing.
  - done=1.
  - Map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause.
  - Unknown address: csr_rdata=0, no write, done=1 (unless the optional feature below is enabled).
- csr_wen is 0 in every cycle except those listed above. *_in buses for unwritten CSRs are don't-care but are driven to 0.
- inst_ready=0 in every non-IDLE state. No back-to-back accept: minimum spacing is 2 cycles for mret/CSR and 3 for ecall.
- Inputs are sampled only at accept; changes on csr_src or pc afterwards have no effect.
- Reset mid-sequence returns to IDLE immediately. Partial writes already committed stay committed; no redirect is issued.

Optional Feature:
ILLEGAL_CSR_TRAP_EN. When defined, a CSR instruction with an unknown address does not complete in CSR_EXEC. It enters TRAP_SAVE with mcause_in=2 (illegal instruction) and mepc_in=pc, followed by TRAP_JUMP. In that case done fires in TRAP_JUMP and csr_rdata=0. When undefined, an unknown address completes silently as described in Behaviour.

Decomposition:
- Shared package csr_pkg:
  - CSR address constants (CSR_MSTATUS=12'h300, CSR_MTVEC=12'h305, CSR_MEPC=12'h341, CSR_MCAUSE=12'h342).
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
  - csr_op encoding.
  - FSM state enum.
  - csr_wen bit indices.
- One sub-module, csr_rmw_alu: combinational op/old/src to new value plus a write-suppress flag. It is reused by the future pipelined CSR path.

Test Plan:
1. Reset with mstatus_out=32'h1808 and mtvec_out=32'h8000_0103: ecall at pc=32'h8000_0040. Cycle+1: csr_wen=0111, mepc_in=32'h8000_0040, mcause_in=11, mstatus_in=32'h1880. Cycle+2: redirect_pc=32'h8000_0100, done=1.
2. mret with mstatus_out=32'h1880 and mepc_out=32'h8000_0044: csr_wen=0100, mstatus_in=32'h1888, redirect_pc=32'h8000_0044, all in one cycle.
3. csrrs to 0x300 with src=32'h8 and old=32'h1800: csr_rdata=32'h1800, mstatus_in=32'h1808, csr_wen=0100. Repeating with src=0 gives csr_wen=0000 and csr_rdata=32'h1800.
4. csrrc to 0x305 with src=32'h3 and old=32'h8000_0103: mtvec_in=32'h8000_0100, csr_wen=1000. Then csrrw to 0x7C0: done=1, csr_rdata=0, csr_wen=0000. With ILLEGAL_CSR_TRAP_EN: mcause_in=2, followed by a redirect to mtvec.
5. is_ecall and is_mret both high together: ecall sequence only. inst_valid held high during TRAP_SAVE: inst_ready=0, no second accept.
6. rst asserted during TRAP_SAVE: outputs 0 immediately, no redirect, inst_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR trap controller: CSR addresses,
// mstatus bit positions, csr_op encoding, FSM states and csr_wen bit indices.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int WEN_MEPC    = 0;
    localparam int WEN_MCAUSE  = 1;
    localparam int WEN_MSTATUS = 2;
    localparam int WEN_MTVEC   = 3;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRAP_SAVE = 3'd1,
        ST_TRAP_JUMP = 3'd2,
        ST_MRET      = 3'd3,
        ST_CSR_EXEC  = 3'd4
    } state_e;

    function automatic logic csr_known(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// EXU instruction handshake plus CSR-file read/write buses of csr_trap_ctrl.
// master = EXU/CSR-file side, slave = the controller.
interface csr_trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            inst_valid;
    logic            inst_ready;
    logic            is_ecall;
    logic            is_mret;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_src;
    logic [XLEN-1:0] pc;

    logic [XLEN-1:0] mepc_out;
    logic [XLEN-1:0] mcause_out;
    logic [XLEN-1:0] mstatus_out;
    logic [XLEN-1:0] mtvec_out;

    logic [XLEN-1:0] mepc_in;
    logic [XLEN-1:0] mcause_in;
    logic [XLEN-1:0] mstatus_in;
    logic [XLEN-1:0] mtvec_in;
    logic [3:0]      csr_wen;

    logic [XLEN-1:0] csr_rdata;
    logic            done;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output inst_valid, is_ecall, is_mret, csr_op, csr_addr, csr_src, pc,
               mepc_out, mcause_out, mstatus_out, mtvec_out,
        input  inst_ready, mepc_in, mcause_in, mstatus_in, mtvec_in, csr_wen,
               csr_rdata, done, redirect_valid, redirect_pc
    );

    modport slave (
        input  inst_valid, is_ecall, is_mret, csr_op, csr_addr, csr_src, pc,
               mepc_out, mcause_out, mstatus_out, mtvec_out,
        output inst_ready, mepc_in, mcause_in, mstatus_in, mtvec_in, csr_wen,
               csr_rdata, done, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/csr_rmw_alu.sv
// Zicsr read-modify-write datapath: new CSR value from op/old/src, plus a flag
// that suppresses the write (RS/RC with a zero source, or no operation).
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  csr_op_e         i_op,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_src,
    output logic [XLEN-1:0] o_new,
    output logic            o_suppress
);

    always_comb begin
        o_new      = '0;
        o_suppress = 1'b1;
        case (i_op)
            CSR_OP_RW: begin
                o_new      = i_src;
                o_suppress = 1'b0;
            end
            CSR_OP_RS: begin
                o_new      = i_old | i_src;
                o_suppress = (i_src == '0);
            end
            CSR_OP_RC: begin
                o_new      = i_old & ~i_src;
                o_suppress = (i_src == '0);
            end
            default: begin
                o_new      = '0;
                o_suppress = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Sequences ecall trap entry, mret and Zicsr RMW against the M-mode CSR file.
// Optional build macro ILLEGAL_CSR_TRAP_EN: unknown CSR addresses trap (mcause 2).
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11)
) (
    input logic           clk,
    input logic           rst,
    csr_trap_ctrl_if.slave bus
);

    state_e          r_state;
    state_e          w_next;
    logic [XLEN-1:0] r_pc;
    csr_op_e         r_op;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_src;

    logic            w_accept;
    logic            w_known;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic            w_suppress;
    logic [XLEN-1:0] w_trap_cause;

    logic [3:0]      w_wen;
    logic [XLEN-1:0] w_mepc_in;
    logic [XLEN-1:0] w_mcause_in;
    logic [XLEN-1:0] w_mstatus_in;
    logic [XLEN-1:0] w_mtvec_in;
    logic [XLEN-1:0] w_rdata;
    logic            w_done;
    logic            w_redirect_valid;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_ready;

    function automatic logic [XLEN-1:0] mstatus_trap_entry(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        r = m;
        r[MSTATUS_MPIE]                  = m[MSTATUS_MIE];
        r[MSTATUS_MIE]                   = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_mret_exit(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        r = m;
        r[MSTATUS_MIE]                   = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                  = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Ready drops combinationally with rst so nothing is accepted during reset.
    assign w_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept = bus.inst_valid && w_ready;
    assign w_known  = csr_known(r_addr);

`ifdef ILLEGAL_CSR_TRAP_EN
    localparam logic [XLEN-1:0] ILLEGAL_CAUSE = XLEN'(2);
    logic r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_illegal <= !bus.is_ecall && !bus.is_mret &&
                         (bus.csr_op != CSR_OP_NONE) && !csr_known(bus.csr_addr);
        end
    end

    assign w_trap_cause = r_illegal ? ILLEGAL_CAUSE : ECALL_CAUSE;
`else
    assign w_trap_cause = ECALL_CAUSE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_op    <= CSR_OP_NONE;
            r_addr  <= '0;
            r_src   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_pc   <= bus.pc;
                r_op   <= csr_op_e'(bus.csr_op);
                r_addr <= bus.csr_addr;
                r_src  <= bus.csr_src;
            end
        end
    end

    always_comb begin
        w_old = '0;
        case (r_addr)
            CSR_MSTATUS: w_old = bus.mstatus_out;
            CSR_MTVEC:   w_old = bus.mtvec_out;
            CSR_MEPC:    w_old = bus.mepc_out;
            CSR_MCAUSE:  w_old = bus.mcause_out;
            default:     w_old = '0;
        endcase
    end

    csr_rmw_alu #(
        .XLEN(XLEN)
    ) u_rmw_alu (
        .i_op      (r_op),
        .i_old     (w_old),
        .i_src     (r_src),
        .o_new     (w_new),
        .o_suppress(w_suppress)
    );

    always_comb begin
        w_next           = r_state;
        w_wen            = '0;
        w_mepc_in        = '0;
        w_mcause_in      = '0;
        w_mstatus_in     = '0;
        w_mtvec_in       = '0;
        w_rdata          = '0;
        w_done           = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.is_ecall)     w_next = ST_TRAP_SAVE;
                    else if (bus.is_mret) w_next = ST_MRET;
                    else                  w_next = ST_CSR_EXEC;
                end
            end
            ST_TRAP_SAVE: begin
                w_wen[WEN_MEPC]    = 1'b1;
                w_wen[WEN_MCAUSE]  = 1'b1;
                w_wen[WEN_MSTATUS] = 1'b1;
                w_mepc_in          = r_pc;
                w_mcause_in        = w_trap_cause;
                w_mstatus_in       = mstatus_trap_entry(bus.mstatus_out);
                w_next             = ST_TRAP_JUMP;
            end
            ST_TRAP_JUMP: begin
                w_redirect_valid = 1'b1;
                w_redirect_pc    = {bus.mtvec_out[XLEN-1:2], 2'b00};
                w_done           = 1'b1;
                w_next           = ST_IDLE;
            end
            ST_MRET: begin
                w_wen[WEN_MSTATUS] = 1'b1;
                w_mstatus_in       = mstatus_mret_exit(bus.mstatus_out);
                w_redirect_valid   = 1'b1;
                w_redirect_pc      = bus.mepc_out;
                w_done             = 1'b1;
                w_next             = ST_IDLE;
            end
            ST_CSR_EXEC: begin
                w_next = ST_IDLE;
                if (r_op == CSR_OP_NONE) begin
                    w_done = 1'b1;
                end else if (!w_known) begin
`ifdef ILLEGAL_CSR_TRAP_EN
                    w_next = ST_TRAP_SAVE;
`else
                    w_done = 1'b1;
`endif
                end else begin
                    w_done  = 1'b1;
                    w_rdata = w_old;
                    if (!w_suppress) begin
                        case (r_addr)
                            CSR_MSTATUS: begin
                                w_wen[WEN_MSTATUS] = 1'b1;
                                w_mstatus_in       = w_new;
                            end
                            CSR_MTVEC: begin
                                w_wen[WEN_MTVEC] = 1'b1;
                                w_mtvec_in       = w_new;
                            end
                            CSR_MEPC: begin
                                w_wen[WEN_MEPC] = 1'b1;
                                w_mepc_in       = w_new;
                            end
                            default: begin
                                w_wen[WEN_MCAUSE] = 1'b1;
                                w_mcause_in       = w_new;
                            end
                        endcase
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.inst_ready     = w_ready;
    assign bus.csr_wen        = w_wen;
    assign bus.mepc_in        = w_mepc_in;
    assign bus.mcause_in      = w_mcause_in;
    assign bus.mstatus_in     = w_mstatus_in;
    assign bus.mtvec_in       = w_mtvec_in;
    assign bus.csr_rdata      = w_rdata;
    assign bus.done           = w_done;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = w_redirect_pc;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed scenarios plus randomized
// instructions checked cycle by cycle against a transaction-level model.
module tb_csr_trap_ctrl;

    logic clk = 1'b0;
    logic rst;

    csr_trap_ctrl_if #(.XLEN(32)) bus ();

    csr_trap_ctrl #(
        .XLEN       (32),
        .ECALL_CAUSE(32'd11)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] rdata;
        logic        done;
        logic        rv;
        logic [31:0] rpc;
    } frame_t;

    frame_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] cur_mepc, cur_mcause, cur_mstatus, cur_mtvec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic frame_t zf();
        frame_t f;
        f.wen = '0; f.mepc = '0; f.mcause = '0; f.mstatus = '0; f.mtvec = '0;
        f.rdata = '0; f.done = 1'b0; f.rv = 1'b0; f.rpc = '0;
        return f;
    endfunction

    task automatic check_frame(input string tag, input frame_t e, input logic rdy);
        chk({tag, ".wen"},     32'(bus.csr_wen),        32'(e.wen));
        chk({tag, ".mepc"},    bus.mepc_in,             e.mepc);
        chk({tag, ".mcause"},  bus.mcause_in,           e.mcause);
        chk({tag, ".mstatus"}, bus.mstatus_in,          e.mstatus);
        chk({tag, ".mtvec"},   bus.mtvec_in,            e.mtvec);
        chk({tag, ".rdata"},   bus.csr_rdata,           e.rdata);
        chk({tag, ".done"},    32'(bus.done),           32'(e.done));
        chk({tag, ".rv"},      32'(bus.redirect_valid), 32'(e.rv));
        chk({tag, ".rpc"},     bus.redirect_pc,         e.rpc);
        chk({tag, ".ready"},   32'(bus.inst_ready),     32'(rdy));
    endtask

    task automatic set_csrs(input logic [31:0] me, mc, ms, mt);
        cur_mepc = me; cur_mcause = mc; cur_mstatus = ms; cur_mtvec = mt;
        bus.mepc_out = me; bus.mcause_out = mc; bus.mstatus_out = ms; bus.mtvec_out = mt;
    endtask

    // Trap entry: save pc/cause, MPIE<-MIE, MIE<-0, MPP<-3; then jump to mtvec base.
    task automatic push_trap(input logic [31:0] cause, input logic [31:0] p);
        frame_t f;
        f = zf();
        f.wen     = 4'b0111;
        f.mepc    = p;
        f.mcause  = cause;
        f.mstatus = (cur_mstatus & ~32'h1888) | 32'h1800 | (((cur_mstatus >> 3) & 32'h1) << 7);
        exp_q.push_back(f);
        f = zf();
        f.rv   = 1'b1;
        f.rpc  = cur_mtvec & ~32'h3;
        f.done = 1'b1;
        exp_q.push_back(f);
    endtask

    task automatic build_expected(input logic ec, mr, input logic [1:0] op,
                                  input logic [11:0] addr, input logic [31:0] src, p);
        frame_t f;
        int idx;
        logic [31:0] old, nv;
        exp_q.delete();
        f = zf();
        if (ec) begin
            push_trap(32'd11, p);
        end else if (mr) begin
            f.wen     = 4'b0100;
            f.mstatus = (cur_mstatus & ~32'h1888) | 32'h1880 | (((cur_mstatus >> 7) & 32'h1) << 3);
            f.rv      = 1'b1;
            f.rpc     = cur_mepc;
            f.done    = 1'b1;
            exp_q.push_back(f);
        end else if (op == 2'd0) begin
            f.done = 1'b1;
            exp_q.push_back(f);
        end else begin
            case (addr)
                12'h341: begin idx = 0; old = cur_mepc;    end
                12'h342: begin idx = 1; old = cur_mcause;  end
                12'h300: begin idx = 2; old = cur_mstatus; end
                12'h305: begin idx = 3; old = cur_mtvec;   end
                default: begin idx = -1; old = '0;         end
            endcase
            if (idx < 0) begin
`ifdef ILLEGAL_CSR_TRAP_EN
                exp_q.push_back(f);
                push_trap(32'd2, p);
`else
                f.done = 1'b1;
                exp_q.push_back(f);
`endif
            end else begin
                nv = (op == 2'd1) ? src : (op == 2'd2) ? (old | src) : (old & ~src);
                f.rdata = old;
                f.done  = 1'b1;
                if (op == 2'd1 || src != 0) begin
                    f.wen = 4'(1 << idx);
                    case (idx)
                        0: f.mepc    = nv;
                        1: f.mcause  = nv;
                        2: f.mstatus = nv;
                        default: f.mtvec = nv;
                    endcase
                end
                exp_q.push_back(f);
            end
        end
    endtask

    // Called at a negedge with the DUT idle; ends at the negedge after the
    // sequence, having checked the idle frame.
    task automatic run_txn(input string tag, input logic ec, mr, input logic [1:0] op,
                           input logic [11:0] addr, input logic [31:0] src, p, input bit hold);
        build_expected(ec, mr, op, addr, src, p);
        bus.is_ecall = ec; bus.is_mret = mr; bus.csr_op = op;
        bus.csr_addr = addr; bus.csr_src = src; bus.pc = p;
        bus.inst_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.inst_valid = 1'b0;
        bus.csr_src = $urandom; bus.pc = $urandom;
        bus.csr_op = 2'($urandom_range(0, 3)); bus.csr_addr = 12'($urandom);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check_frame(tag, exp_q[i], 1'b0);
        end
        bus.inst_valid = 1'b0;
        @(negedge clk);
        check_frame({tag, ".idle"}, zf(), 1'b1);
    endtask

    initial begin
        logic [11:0] ra;
        logic [31:0] rs;
        int k;
        frame_t z;
        z = zf();
        rst = 1'b1;
        bus.inst_valid = 1'b0; bus.is_ecall = 1'b0; bus.is_mret = 1'b0;
        bus.csr_op = 2'b00; bus.csr_addr = '0; bus.csr_src = '0; bus.pc = '0;
        set_csrs(32'h0, 32'h0, 32'h1808, 32'h8000_0103);
        #1;
        check_frame("reset", z, 1'b0);
        repeat (2) @(negedge clk);
        bus.inst_valid = 1'b1;
        check_frame("reset_valid", z, 1'b0);
        bus.inst_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(bus.inst_ready), 32'd1);
        @(negedge clk);

        // ecall trap entry and jump
        run_txn("ecall", 1'b1, 1'b0, 2'b00, 12'h000, 32'h0, 32'h8000_0040, 1'b0);
        // mret
        set_csrs(32'h8000_0044, 32'd11, 32'h1880, 32'h8000_0103);
        run_txn("mret", 1'b0, 1'b1, 2'b00, 12'h000, 32'h0, 32'h8000_0044, 1'b0);
        // csrrs mstatus, then zero-source variant
        set_csrs(32'h0, 32'h0, 32'h1800, 32'h0);
        run_txn("csrrs", 1'b0, 1'b0, 2'b10, 12'h300, 32'h8, 32'h100, 1'b0);
        run_txn("csrrs0", 1'b0, 1'b0, 2'b10, 12'h300, 32'h0, 32'h104, 1'b0);
        // csrrc mtvec, then unknown address
        set_csrs(32'h0, 32'h0, 32'h1800, 32'h8000_0103);
        run_txn("csrrc", 1'b0, 1'b0, 2'b11, 12'h305, 32'h3, 32'h108, 1'b0);
        run_txn("csrrw_unk", 1'b0, 1'b0, 2'b01, 12'h7C0, 32'hDEAD_BEEF, 32'h10C, 1'b0);
        // ecall wins over mret and csr_op; valid held high through the sequence
        set_csrs(32'h1234_5678, 32'h5, 32'h0000_0088, 32'h4000_0002);
        run_txn("ecall_mret", 1'b1, 1'b1, 2'b01, 12'h300, 32'hFFFF_FFFF, 32'h2000_0010, 1'b1);
        run_txn("none", 1'b0, 1'b0, 2'b00, 12'h300, 32'h1, 32'h2000_0014, 1'b0);

        // reset during TRAP_SAVE
        set_csrs(32'h0, 32'h0, 32'h1808, 32'h8000_0103);
        bus.is_ecall = 1'b1; bus.is_mret = 1'b0; bus.pc = 32'h8000_0200;
        bus.inst_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.inst_valid = 1'b0; bus.is_ecall = 1'b0;
        @(negedge clk);
        chk("rst_mid.wen_before", 32'(bus.csr_wen), 32'h7);
        rst = 1'b1;
        #1;
        check_frame("rst_mid.async", z, 1'b0);
        @(negedge clk);
        check_frame("rst_mid.held", z, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_mid.ready", 32'(bus.inst_ready), 32'd1);
        @(negedge clk);
        check_frame("rst_mid.after", z, 1'b1);

        // randomized instructions
        for (int n = 0; n < 300; n++) begin
            set_csrs($urandom, $urandom, $urandom, $urandom);
            k = $urandom_range(0, 5);
            case (k)
                0, 1, 2, 3: ra = (k == 0) ? 12'h300 : (k == 1) ? 12'h305 : (k == 2) ? 12'h341 : 12'h342;
                4: ra = 12'h7C0;
                default: ra = 12'($urandom);
            endcase
            rs = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            k = $urandom_range(0, 9);
            run_txn("rand", k < 2, (k >= 2 && k < 4) || (k == 0 && $urandom_range(0, 1) == 1),
                    2'($urandom_range(0, 3)), ra, rs, $urandom, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
